// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default timing for the button debouncer
package debounce_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
    localparam int DEBOUNCE_DEFAULT   = 1_000_000;
    localparam int LONG_PRESS_DEFAULT = 50_000_000;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce FSM and hold timer for one active-low button
module button_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

    logic [1:0]    sync_q;
    btn_state_t    state_q;
    logic [DW-1:0] deb_q;
    logic [HW-1:0] hold_q;
    logic          fired_q;
    logic          sync_i;

    assign sync_i = sync_q[1];

    // fired_q keeps the saturated hold counter from re-triggering btn_long
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], ~btn_n_i};
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            case (state_q)
                IDLE: if (sync_i) begin
                    state_q <= PRESS_WAIT;
                    deb_q   <= '0;
                end
                PRESS_WAIT: if (!sync_i) begin
                    state_q <= IDLE;
                end else if (deb_q == DEB_MAX) begin
                    state_q <= PRESSED;
                    press_o <= 1'b1;
                    level_o <= 1'b1;
                    hold_q  <= '0;
                    fired_q <= 1'b0;
                end else begin
                    deb_q <= deb_q + 1'b1;
                end
                PRESSED: if (!sync_i) begin
                    state_q <= RELEASE_WAIT;
                    deb_q   <= '0;
                end else if (hold_q == HOLD_MAX) begin
                    long_o  <= !fired_q;
                    fired_q <= 1'b1;
                end else begin
                    hold_q <= hold_q + 1'b1;
                end
                RELEASE_WAIT: if (sync_i) begin
                    state_q <= PRESSED;
                end else if (deb_q == DEB_MAX) begin
                    state_q   <= IDLE;
                    release_o <= 1'b1;
                    level_o   <= 1'b0;
                end else begin
                    deb_q <= deb_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: independent debounce channels for the board push-buttons
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N_BUTTONS         = 4,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [N_BUTTONS-1:0] btn_raw_n,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic [N_BUTTONS-1:0] btn_long
);
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk_i    (HCLK),
            .rst_i    (HRESET),
            .btn_n_i  (btn_raw_n[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .long_o   (btn_long[i])
        );
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of debounce latency, filtering, long press and reset abort
module tb_button_debouncer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = 4'b0000;
    logic [3:0] lvl, prs, rel, lng;
    int         total = 0;
    int         passed = 0;

    button_debouncer #(
        .N_BUTTONS        (4),
        .DEBOUNCE_CYCLES  (8),
        .LONG_PRESS_CYCLES(32)
    ) dut (
        .HCLK       (clk),
        .HRESET     (rst),
        .btn_raw_n  (raw),
        .btn_level  (lvl),
        .btn_press  (prs),
        .btn_release(rel),
        .btn_long   (lng)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // raw already applied; expect press pulse `mask` on the 11th edge
    task automatic expect_press(input string tag, input logic [3:0] mask, input logic [3:0] lvl_before);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk({tag, "_wait_prs"}, prs, 4'b0000);
            chk({tag, "_wait_lvl"}, lvl, lvl_before);
        end
        tick();
        chk({tag, "_prs"}, prs, mask);
        chk({tag, "_lvl"}, lvl, lvl_before | mask);
    endtask

    task automatic expect_release(input string tag, input logic [3:0] mask, input logic [3:0] lvl_before);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk({tag, "_wait_rel"}, rel, 4'b0000);
            chk({tag, "_wait_lvl"}, lvl, lvl_before);
        end
        tick();
        chk({tag, "_rel"}, rel, mask);
        chk({tag, "_lvl"}, lvl, lvl_before & ~mask);
    endtask

    initial begin
        // 1: reset with all buttons held, then every channel presses on the 11th edge
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_lvl", lvl, 4'b0000);
            chk("rst_pulses", prs | rel | lng, 4'b0000);
        end
        rst = 1'b0;
        expect_press("t1", 4'b1111, 4'b0000);
        raw = 4'b1111;
        tick();
        chk("t1_prs_once", prs, 4'b0000);
        chk("t1_lvl_hold", lvl, 4'b1111);
        for (int k = 2; k <= 10; k++) begin
            tick();
            chk("t1_wait_rel", rel, 4'b0000);
        end
        tick();
        chk("t1_rel", rel, 4'b1111);
        chk("t1_rel_lvl", lvl, 4'b0000);
        tick();
        chk("t1_rel_once", rel, 4'b0000);
        // 2: clean press on button 0
        raw = 4'b1110;
        expect_press("t2", 4'b0001, 4'b0000);
        tick();
        chk("t2_prs_once", prs, 4'b0000);
        chk("t2_lvl", lvl, 4'b0001);
        // 5: release glitch of 4 cycles on button 0
        raw = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_glitch_pulses", prs | rel | lng, 4'b0000);
            chk("t5_glitch_lvl", lvl, 4'b0001);
        end
        raw = 4'b1110;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t5_after_pulses", prs | rel | lng, 4'b0000);
            chk("t5_after_lvl", lvl, 4'b0001);
        end
        raw = 4'b1111;
        expect_release("t5", 4'b0001, 4'b0001);
        // 3: bounce on button 1, then hold low
        for (int s = 0; s < 8; s++) begin
            raw = (s % 2 == 0) ? 4'b1101 : 4'b1111;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("t3_bounce_pulses", prs | rel | lng, 4'b0000);
                chk("t3_bounce_lvl", lvl, 4'b0000);
            end
        end
        raw = 4'b1101;
        expect_press("t3", 4'b0010, 4'b0000);
        raw = 4'b1111;
        expect_release("t3", 4'b0010, 4'b0010);
        // 4: long press on button 2, held 60 cycles after the press pulse
        raw = 4'b1011;
        expect_press("t4", 4'b0100, 4'b0000);
        for (int k = 1; k <= 60; k++) begin
            tick();
            chk("t4_long", lng, (k == 32) ? 4'b0100 : 4'b0000);
            chk("t4_hold_lvl", lvl, 4'b0100);
        end
        raw = 4'b1111;
        expect_release("t4", 4'b0100, 4'b0100);
        // 6a: simultaneous presses on buttons 0 and 3
        raw = 4'b0110;
        expect_press("t6", 4'b1001, 4'b0000);
        raw = 4'b1111;
        expect_release("t6", 4'b1001, 4'b1001);
        // 6b: reset 5 edges into PRESS_WAIT aborts the press
        raw = 4'b1101;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6b_pw_prs", prs, 4'b0000);
        end
        rst = 1'b1;
        raw = 4'b1111;
        tick();
        chk("t6b_rst_lvl", lvl, 4'b0000);
        chk("t6b_rst_pulses", prs | rel | lng, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("t6b_abort_prs", prs, 4'b0000);
            chk("t6b_abort_lvl", lvl, 4'b0000);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces and conditions the active-low push-button inputs of the DE1-SoC board before they reach the SoC's `Buttons` input and any other board-level logic. Each button has its own channel:
- a two-flop synchroniser;
- a four-state debounce FSM;
- a hold timer.

Each channel produces a stable level, one-cycle press and release pulses, and a one-shot long-press pulse. The block sits between the raw `KEY` pins and the SoC in the board wrapper.

## Interface
Parameters:
- `N_BUTTONS`, default 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the input must stay stable to be accepted (20 ms at 50 MHz). Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 50_000_000: cycles held after the press is accepted before `btn_long` fires (1 s). Must be ≥ 2.

Ports:
- `HCLK` input, 1 bit: system clock, rising edge.
- `HRESET` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `btn_raw_n` input, `N_BUTTONS` bits: raw asynchronous button pins; 0 = pressed.
- `btn_level` output, `N_BUTTONS` bits: debounced state; 1 = pressed.
- `btn_press` output, `N_BUTTONS` bits: one-cycle pulse when a press is accepted.
- `btn_release` output, `N_BUTTONS` bits: one-cycle pulse when a release is accepted.
- `btn_long` output, `N_BUTTONS` bits: one-cycle pulse, at most once per press, when the hold time reaches `LONG_PRESS_CYCLES`.

## Operation
- **Synchroniser.** Two flops per channel sample `~btn_raw_n[i]`; the second flop is `sync_i` (1 = pressed). Both flops reset to 0.
- **FSM states.** `IDLE`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`.
- **Debounce counter.** Width `$clog2(DEBOUNCE_CYCLES)`.
- **Hold counter.** Width `$clog2(LONG_PRESS_CYCLES)`; saturates.
- **`IDLE`.** If `sync_i` = 1: go to `PRESS_WAIT` and clear the debounce counter.
- **`PRESS_WAIT`.**
  - If `sync_i` = 0: return to `IDLE`. This is a bounce; no output.
  - Else, if the debounce counter = `DEBOUNCE_CYCLES`-1: go to `PRESSED`, pulse `btn_press`, clear the hold counter.
  - Otherwise increment the debounce counter.
- **`PRESSED`.**
  - If `sync_i` = 0: go to `RELEASE_WAIT` and clear the debounce counter.
  - Else increment the hold counter. When the hold counter = `LONG_PRESS_CYCLES`-1, pulse `btn_long`. The hold counter then saturates, so there is no repeat.
- **`RELEASE_WAIT`.**
  - If `sync_i` = 1: return to `PRESSED`. This is a bounce. The hold counter was frozen while in `RELEASE_WAIT` and resumes from its frozen value.
  - Else, if the debounce counter = `DEBOUNCE_CYCLES`-1: go to `IDLE` and pulse `btn_release`.
  - Otherwise increment the debounce counter.
- **`btn_level[i]`** = 1 in `PRESSED` and `RELEASE_WAIT`; 0 otherwise.
- **Registered outputs.** All outputs are registered and change only on `HCLK` rising edges. Pulses last exactly one cycle.
- **Channel independence.** Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle.

## Timing
- **Reset.** While `HRESET` = 1 at a rising edge, the following are forced to 0 / `IDLE`: all outputs, synchroniser flops, counters and FSM state. Reset mid-debounce or mid-hold aborts the operation with no pulse.
- **Press latency.** Take edge 1 as the first edge that samples the press, with the input stable thereafter. `btn_press` and `btn_level` rise after edge `DEBOUNCE_CYCLES`+3.
- **Release latency.** Symmetric: `btn_release` pulses and `btn_level` falls after edge `DEBOUNCE_CYCLES`+3, counted from the first edge that samples the release.
- **Long press.** `btn_long` pulses exactly `LONG_PRESS_CYCLES` cycles after `btn_press`, provided the input never leaves `PRESSED`.
- **Long press across a release bounce.** If the input bounces into `RELEASE_WAIT` and back, the `btn_long` pulse is delayed by the cycles spent in `RELEASE_WAIT`.
- **Filtering.** Any glitch shorter than `DEBOUNCE_CYCLES`+1 cycles produces no pulse and no level change.
- **Release before long press.** A press released before the long threshold produces `btn_press` and `btn_release` only.

## Structure
- **Package `debounce_pkg`:**
  - enum `btn_state_t` {`IDLE`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`};
  - default constants `DEBOUNCE_DEFAULT` and `LONG_PRESS_DEFAULT`.
- **Sub-module `button_channel`:** one synchroniser, FSM and counter set per channel, with scalar ports.
- **Top level:** instantiates `button_channel` `N_BUTTONS` times in a generate loop and concatenates the outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8 and `LONG_PRESS_CYCLES`=32.
1. **Reset with button held.** Hold `HRESET`=1 for 3 cycles with `btn_raw_n`=4'b0000 → all outputs are 0 during reset. After reset deasserts, every channel pulses `btn_press` at the 11th edge and `btn_level`=4'b1111.
2. **Clean press on button 0.** Drive `btn_raw_n[0]` 1→0 and hold → `btn_press`=4'b0001 for exactly one cycle after edge 11 and `btn_level[0]`=1 from the same cycle. Other channels stay 0.
3. **Bounce.** Toggle `btn_raw_n[1]` every 3 cycles for 24 cycles, then hold it low → no pulses during the bouncing. Exactly one `btn_press[1]` occurs 11 edges after the final transition.
4. **Long press and release.** Hold button 2 for 60 cycles after its press pulse, then release → `btn_long[2]` pulses once, 32 cycles after `btn_press[2]`. `btn_release[2]` pulses 11 edges after the release, with `btn_level[2]` falling in the same cycle.
5. **Release glitch.** While button 0 is `PRESSED`, drive it high for 4 cycles, then low again → no `btn_release`, no second `btn_press`, and `btn_level[0]` stays 1.
6. **Simultaneous presses and reset abort.**
   - Press buttons 0 and 3 on the same edge → `btn_press`=4'b1001 in a single cycle.
   - Press button 1, then assert `HRESET` 5 edges into `PRESS_WAIT` → no `btn_press[1]`, and `btn_level[1]`=0.
